// File: rtl/matmul_controller.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_controller
//  Purpose  : Sequencer for the NxN matrix-multiply datapath. Loads A and B
//             from a byte stream, runs the multiply-accumulate for every
//             element of C, then streams each 18-bit result as three bytes.
//  Revision : 1.0  initial release
// ============================================================================
module matmul_controller #(
    parameter int N             = 4,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     m1EN,
    output logic                     m1rEN,
    output logic                     m1wEN,
    output logic                     m2EN,
    output logic                     m2rEN,
    output logic                     m2wEN,
    output logic                     m3EN,
    output logic                     m3rEN,
    output logic                     m3wEN,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic [ADDRESS_WIDTH-1:0] addr3,
    output logic                     mult_ld,
    output logic                     mult_rst,
    output logic [1:0]               shift_cnt
);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_LOAD_A   = 4'd1;
    localparam logic [3:0] c_ST_LOAD_B   = 4'd2;
    localparam logic [3:0] c_ST_CLR      = 4'd3;
    localparam logic [3:0] c_ST_MAC      = 4'd4;
    localparam logic [3:0] c_ST_WR       = 4'd5;
    localparam logic [3:0] c_ST_OUT_RD   = 4'd6;
    localparam logic [3:0] c_ST_OUT_EMIT = 4'd7;
    localparam logic [3:0] c_ST_DONE     = 4'd8;

    localparam logic [ADDRESS_WIDTH-1:0] c_n      = ADDRESS_WIDTH'(N);
    localparam logic [ADDRESS_WIDTH-1:0] c_n_m1   = ADDRESS_WIDTH'(N - 1);
    localparam logic [ADDRESS_WIDTH-1:0] c_last_e = ADDRESS_WIDTH'(N * N - 1);
    localparam logic [1:0]               c_last_s = 2'd2;

    logic [3:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_e;   // element counter for load and output phases
    logic [ADDRESS_WIDTH-1:0] r_i;   // result row
    logic [ADDRESS_WIDTH-1:0] r_j;   // result column
    logic [ADDRESS_WIDTH-1:0] r_k;   // MAC step, runs 0..N (one extra step drains the read pipe)
    logic [1:0]               r_s;   // output byte select

    // State and counter sequencing; only handshakes advance the stream phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_e     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_s     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_e     <= '0;
                        r_state <= c_ST_LOAD_A;
                    end
                end
                c_ST_LOAD_A: begin
                    if (in_valid) begin
                        if (r_e == c_last_e) begin
                            r_e     <= '0;
                            r_state <= c_ST_LOAD_B;
                        end else begin
                            r_e <= r_e + 1'b1;
                        end
                    end
                end
                c_ST_LOAD_B: begin
                    if (in_valid) begin
                        if (r_e == c_last_e) begin
                            r_e     <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_state <= c_ST_CLR;
                        end else begin
                            r_e <= r_e + 1'b1;
                        end
                    end
                end
                c_ST_CLR: begin
                    r_k     <= '0;
                    r_state <= c_ST_MAC;
                end
                c_ST_MAC: begin
                    if (r_k == c_n) begin
                        r_state <= c_ST_WR;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_ST_WR: begin
                    if (r_j == c_n_m1) begin
                        r_j <= '0;
                        if (r_i == c_n_m1) begin
                            r_i     <= '0;
                            r_e     <= '0;
                            r_state <= c_ST_OUT_RD;
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= c_ST_CLR;
                        end
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_state <= c_ST_CLR;
                    end
                end
                c_ST_OUT_RD: begin
                    r_s     <= '0;
                    r_state <= c_ST_OUT_EMIT;
                end
                c_ST_OUT_EMIT: begin
                    if (out_ready) begin
                        if (r_s == c_last_s) begin
                            r_s <= '0;
                            if (r_e == c_last_e) begin
                                r_e     <= '0;
                                r_state <= c_ST_DONE;
                            end else begin
                                r_e     <= r_e + 1'b1;
                                r_state <= c_ST_OUT_RD;
                            end
                        end else begin
                            r_s <= r_s + 2'd1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Datapath control decode from the current state and counters.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (r_state != c_ST_IDLE);
        done      = 1'b0;
        m1EN      = 1'b0;
        m1rEN     = 1'b0;
        m1wEN     = 1'b0;
        m2EN      = 1'b0;
        m2rEN     = 1'b0;
        m2wEN     = 1'b0;
        m3EN      = 1'b0;
        m3rEN     = 1'b0;
        m3wEN     = 1'b0;
        addr1     = '0;
        addr2     = '0;
        addr3     = '0;
        mult_ld   = 1'b0;
        mult_rst  = 1'b0;
        shift_cnt = 2'd0;
        case (r_state)
            c_ST_LOAD_A: begin
                in_ready = 1'b1;
                m1EN     = in_valid;
                m1wEN    = in_valid;
                addr1    = r_e;
            end
            c_ST_LOAD_B: begin
                in_ready = 1'b1;
                m2EN     = in_valid;
                m2wEN    = in_valid;
                addr2    = r_e;
            end
            c_ST_CLR: begin
                mult_rst = 1'b1;
            end
            c_ST_MAC: begin
                if (r_k < c_n) begin
                    m1EN  = 1'b1;
                    m1rEN = 1'b1;
                    m2EN  = 1'b1;
                    m2rEN = 1'b1;
                    addr1 = r_i * c_n + r_k;
                    addr2 = r_k * c_n + r_j;
                end
                // Read data lags the address by one cycle, so accumulation starts at k=1.
                mult_ld = (r_k != '0);
            end
            c_ST_WR: begin
                m3EN  = 1'b1;
                m3wEN = 1'b1;
                addr3 = r_i * c_n + r_j;
            end
            c_ST_OUT_RD: begin
                m3EN  = 1'b1;
                m3rEN = 1'b1;
                addr3 = r_e;
            end
            c_ST_OUT_EMIT: begin
                // Keep re-reading the same element so the shifter input stays stable.
                out_valid = 1'b1;
                shift_cnt = r_s;
                m3EN      = 1'b1;
                m3rEN     = 1'b1;
                addr3     = r_e;
            end
            c_ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_controller
//  Purpose  : Bench for matmul_controller with a behavioural datapath
//             (three registered-read memories, accumulator, byte shifter)
//             and a byte scoreboard fed from a reference matrix product.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matmul_controller;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int NE = N * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, busy, done;
    logic m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN;
    logic [AW-1:0] addr1, addr2, addr3;
    logic mult_ld, mult_rst;
    logic [1:0] shift_cnt;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    matmul_controller #(.N(N), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .m1EN(m1EN), .m1rEN(m1rEN), .m1wEN(m1wEN),
        .m2EN(m2EN), .m2rEN(m2rEN), .m2wEN(m2wEN),
        .m3EN(m3EN), .m3rEN(m3rEN), .m3wEN(m3wEN),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .mult_ld(mult_ld), .mult_rst(mult_rst), .shift_cnt(shift_cnt)
    );

    // Behavioural datapath
    logic [7:0]  mem1 [NE];
    logic [7:0]  mem2 [NE];
    logic [17:0] mem3 [NE];
    logic [7:0]  rd1 = 8'h00;
    logic [7:0]  rd2 = 8'h00;
    logic [17:0] rd3 = 18'h0;
    logic [17:0] acc = 18'h0;

    always @(posedge clk) begin
        if (m1EN && m1wEN) mem1[addr1[3:0]] <= data_in;
        if (m1EN && m1rEN) rd1 <= mem1[addr1[3:0]];
        if (m2EN && m2wEN) mem2[addr2[3:0]] <= data_in;
        if (m2EN && m2rEN) rd2 <= mem2[addr2[3:0]];
        if (m3EN && m3wEN) mem3[addr3[3:0]] <= acc;
        if (m3EN && m3rEN) rd3 <= mem3[addr3[3:0]];
        if (mult_rst)     acc <= 18'h0;
        else if (mult_ld) acc <= acc + 18'(rd1) * 18'(rd2);
    end

    always_comb begin
        case (shift_cnt)
            2'd0:    data_out = rd3[7:0];
            2'd1:    data_out = rd3[15:8];
            default: data_out = {6'b0, rd3[17:16]};
        endcase
    end

    logic [8:0]  en9;
    logic [34:0] all_outs;
    assign en9 = {m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN};
    assign all_outs = {in_ready, out_valid, busy, done, en9, addr1, addr2, addr3,
                       mult_ld, mult_rst, shift_cnt};

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [7:0]  exp_q [$];
    int          mat_a [NE];
    int          mat_b [NE];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // 0: A=I, B=1..16   1: all 0xFF   2: A=1..16, B=16..1   3: A=0..15, B=all 1
    task automatic load_pattern(input int pat);
        for (int x = 0; x < NE; x++) begin
            case (pat)
                0: begin mat_a[x] = ((x / N) == (x % N)) ? 1 : 0; mat_b[x] = x + 1; end
                1: begin mat_a[x] = 255; mat_b[x] = 255; end
                2: begin mat_a[x] = x + 1; mat_b[x] = NE - x; end
                default: begin mat_a[x] = x; mat_b[x] = 1; end
            endcase
        end
    endtask

    // Reference product, pushed as LSB-first byte triples
    task automatic push_expected();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int v = 0;
                for (int q = 0; q < N; q++) v += mat_a[r*N+q] * mat_b[q*N+c];
                exp_q.push_back(8'(v));
                exp_q.push_back(8'(v >> 8));
                exp_q.push_back(8'((v >> 16) & 3));
            end
        end
    endtask

    // Runs one job from a negedge in IDLE; returns at a negedge.
    task automatic run_job(input int in_gap, input int out_gap, input bit poke,
                           input int abort_wr, input int exp_cycles, input logic [23:0] exp_e0);
        int ptr = 0, nbytes = 0, busy_cyc = 0, done_cnt = 0, wr_cnt = 0;
        bit finished = 1'b0, aborted = 1'b0, hold = 1'b0;
        logic [10:0] held = '0;
        logic [23:0] e0 = '0;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            in_valid  = (ptr < 2*NE) && ($urandom_range(99) >= in_gap);
            data_in   = (ptr < NE) ? 8'(mat_a[ptr]) : (ptr < 2*NE) ? 8'(mat_b[ptr-NE]) : 8'h00;
            out_ready = ($urandom_range(99) >= out_gap);
            start     = poke && ((ptr == NE + 4) || (nbytes == 10));
            #1;
            if (hold) chk("hold_stable", {out_valid, shift_cnt, data_out}, held);
            hold = out_valid && !out_ready;
            held = {out_valid, shift_cnt, data_out};
            if (busy) begin
                busy_cyc++;
                chk("exclusive", {mult_ld & mult_rst,
                     ((int'(m1EN & m1wEN) + int'(m2EN & m2wEN) + int'(m3EN & m3wEN)) > 1)}, 0);
            end
            if (in_ready && !in_valid) chk("stall_enables", en9, 0);
            if (in_ready && in_valid) begin
                if (ptr < NE) chk("load_a_wr", {m1EN, m1wEN, m2EN, m2wEN, addr1}, {4'b1100, 6'(ptr)});
                else          chk("load_b_wr", {m1EN, m1wEN, m2EN, m2wEN, addr2}, {4'b0011, 6'(ptr-NE)});
                ptr++;
            end
            if (m3EN && m3wEN) wr_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", nbytes, 48);
                else begin
                    logic [7:0] eb = exp_q.pop_front();
                    chk("out_byte", data_out, eb);
                end
                if (nbytes < 3) e0[8*nbytes +: 8] = data_out;
                nbytes++;
            end
            if (done) done_cnt++;
            if (done_cnt > 0 && !done) begin
                chk("idle_after_done", {busy, done, in_ready, out_valid}, 0);
                finished = 1'b1;
            end
            if (abort_wr >= 0 && wr_cnt == abort_wr && mult_ld) begin
                #2 rst = 1'b1;
                #1;
                chk("async_reset_outs", all_outs, 0);
                chk("async_reset_busy", busy, 0);
                @(negedge clk);
                rst = 1'b0;
                exp_q.delete();
                aborted  = 1'b1;
                finished = 1'b1;
            end
            if (!aborted) @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!finished) chk("timeout", 1, 0);
        if (!aborted) begin
            chk("done_once", done_cnt, 1);
            chk("bytes_out", nbytes, 3*NE);
            chk("bytes_in", ptr, 2*NE);
            chk("queue_empty", exp_q.size(), 0);
            chk("elem0", e0, exp_e0);
            if (exp_cycles > 0) chk("job_cycles", busy_cyc, exp_cycles);
            exp_q.delete();
        end
    endtask

    typedef struct {
        int          pat;
        int          in_gap;
        int          out_gap;
        bit          poke;
        int          abort_wr;
        int          exp_cycles;
        logic [23:0] exp_e0;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0,  0,  0, 1'b0, -1, 209, 24'h000001};  // identity
        vecs[1] = '{1,  0,  0, 1'b0, -1, 209, 24'h03F804};  // saturation
        vecs[2] = '{2, 30, 40, 1'b0, -1,   0, 24'h000050};  // gaps/backpressure
        vecs[3] = '{2,  0,  0, 1'b0,  5,   0, 24'h000000};  // abort in element 5
        vecs[4] = '{3, 20, 20, 1'b0, -1,   0, 24'h000006};  // new job after abort
        vecs[5] = '{0,  0,  0, 1'b1, -1, 209, 24'h000001};  // start pokes ignored

        #1;
        chk("reset_outs", all_outs, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", all_outs, 0);

        for (int v = 0; v < 6; v++) begin
            load_pattern(vecs[v].pat);
            push_expected();
            run_job(vecs[v].in_gap, vecs[v].out_gap, vecs[v].poke,
                    vecs[v].abort_wr, vecs[v].exp_cycles, vecs[v].exp_e0);
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
